// File: rtl/pass_through_queue_array.sv
// Array of independent val/rdy lanes, each buffered by its own nentries-deep FIFO.
// Flags depend only on registered state (and reset); there is no bypass path from input to output.
module pass_through_queue_array #(
  parameter int unsigned nports   = 2,
  parameter int unsigned nbits    = 32,
  parameter int unsigned nentries = 2,
  localparam int unsigned cbits   = $clog2(nentries + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_val  [nports],
  output logic             in_rdy  [nports],
  input  logic [nbits-1:0] in_msg  [nports],
  output logic             out_val [nports],
  input  logic             out_rdy [nports],
  output logic [nbits-1:0] out_msg [nports],
  output logic [cbits-1:0] count   [nports]
);

  localparam int unsigned pbits = (nentries > 1) ? $clog2(nentries) : 1;

  for (genvar i = 0; i < nports; i++) begin : g_lane
    logic [nbits-1:0] mem [nentries];
    logic [pbits-1:0] head;
    logic [pbits-1:0] tail;
    logic [cbits-1:0] cnt;
    logic             enq;
    logic             deq;

    assign in_rdy[i]  = !reset && (cnt < cbits'(nentries));
    assign out_val[i] = !reset && (cnt != '0);
    assign out_msg[i] = mem[head];
    assign count[i]   = cnt;

    assign enq = in_val[i] && in_rdy[i];
    assign deq = out_val[i] && out_rdy[i];

    // Pointer wrap is an explicit compare so non-power-of-two depths work.
    always_ff @(posedge clk) begin
      if (reset) begin
        head <= '0;
        tail <= '0;
        cnt  <= '0;
      end else begin
        if (enq) begin
          tail <= (tail == pbits'(nentries - 1)) ? '0 : tail + 1'b1;
        end
        if (deq) begin
          head <= (head == pbits'(nentries - 1)) ? '0 : head + 1'b1;
        end
        case ({enq, deq})
          2'b10:   cnt <= cnt + 1'b1;
          2'b01:   cnt <= cnt - 1'b1;
          default: cnt <= cnt;
        endcase
      end
    end

    // Storage is not reset; enq already excludes reset cycles.
    always_ff @(posedge clk) begin
      if (enq) begin
        mem[tail] <= in_msg[i];
      end
    end

    always_ff @(posedge clk) begin
      if (!reset) begin
        assert (cnt <= cbits'(nentries));
        assert (!(enq && (cnt == cbits'(nentries))));
        assert (!(deq && (cnt == '0)));
      end
    end
  end

endmodule

// File: tb/tb_pass_through_queue_array.sv
// Randomized scoreboard bench: two instances (4 lanes x depth 4, 2 lanes x depth 1)
// checked against per-lane queue models of the lanes' contents.
module tb_pass_through_queue_array;

  localparam int unsigned NA = 4;
  localparam int unsigned DA = 4;
  localparam int unsigned NB = 2;
  localparam int unsigned DB = 1;

  logic clk = 1'b0;
  logic reset;

  logic        a_in_val  [NA];
  logic        a_in_rdy  [NA];
  logic [31:0] a_in_msg  [NA];
  logic        a_out_val [NA];
  logic        a_out_rdy [NA];
  logic [31:0] a_out_msg [NA];
  logic [2:0]  a_count   [NA];

  logic        b_in_val  [NB];
  logic        b_in_rdy  [NB];
  logic [31:0] b_in_msg  [NB];
  logic        b_out_val [NB];
  logic        b_out_rdy [NB];
  logic [31:0] b_out_msg [NB];
  logic [0:0]  b_count   [NB];

  int checks = 0;
  int errors = 0;
  bit armed  = 1'b0;
  logic [31:0] seq = 32'h100;

  // Model: one queue per lane (A lanes 0..3, B lanes 4..5).
  logic [31:0] q [NA+NB][$];

  pass_through_queue_array #(.nports(NA), .nbits(32), .nentries(DA)) u_a (
    .clk(clk), .reset(reset),
    .in_val(a_in_val), .in_rdy(a_in_rdy), .in_msg(a_in_msg),
    .out_val(a_out_val), .out_rdy(a_out_rdy), .out_msg(a_out_msg),
    .count(a_count)
  );

  pass_through_queue_array #(.nports(NB), .nbits(32), .nentries(DB)) u_b (
    .clk(clk), .reset(reset),
    .in_val(b_in_val), .in_rdy(b_in_rdy), .in_msg(b_in_msg),
    .out_val(b_out_val), .out_rdy(b_out_rdy), .out_msg(b_out_msg),
    .count(b_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s lane%0d t=%0t: got %h expected %h", name, k, $time, act, exp);
    end
  endtask

  // Compare one lane against its queue, then apply the coming edge to the model.
  task automatic sb_lane(input int k, input int depth, input logic iv, input logic ir,
                         input logic ov, input logic ordy, input logic [31:0] im,
                         input logic [31:0] om, input logic [2:0] cnt);
    logic exp_ir;
    logic exp_ov;
    exp_ir = !reset && (q[k].size() < depth);
    exp_ov = !reset && (q[k].size() != 0);
    if (armed) begin
      check("in_rdy", k, 32'(ir), 32'(exp_ir));
      check("out_val", k, 32'(ov), 32'(exp_ov));
      check("count", k, 32'(cnt), 32'(q[k].size()));
      if (exp_ov) check("out_msg", k, om, q[k][0]);
    end
    if (reset) begin
      q[k].delete();
    end else begin
      if (exp_ov && ordy) void'(q[k].pop_front());
      if (exp_ir && iv) q[k].push_back(im);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < NA; i++)
      sb_lane(i, DA, a_in_val[i], a_in_rdy[i], a_out_val[i], a_out_rdy[i],
              a_in_msg[i], a_out_msg[i], a_count[i]);
    for (int i = 0; i < NB; i++)
      sb_lane(NA + i, DB, b_in_val[i], b_in_rdy[i], b_out_val[i], b_out_rdy[i],
              b_in_msg[i], b_out_msg[i], {2'b00, b_count[i]});
    if (reset) armed = 1'b1;
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_all(input logic rdy);
    for (int i = 0; i < NA; i++) begin
      a_in_val[i] = 1'b0; a_out_rdy[i] = rdy; a_in_msg[i] = '0;
    end
    for (int i = 0; i < NB; i++) begin
      b_in_val[i] = 1'b0; b_out_rdy[i] = rdy; b_in_msg[i] = '0;
    end
  endtask

  task automatic rand_b();
    for (int i = 0; i < NB; i++) begin
      b_in_val[i]  = 1'($urandom);
      b_out_rdy[i] = 1'($urandom);
      b_in_msg[i]  = $urandom;
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_all(1'b0);
    cyc(2);
    reset = 1'b0;
    cyc(2);

    // Single message on lane 0, lane 1 stays empty.
    a_in_val[0] = 1'b1; a_in_msg[0] = 32'hDEADBEEF; a_out_rdy[0] = 1'b1;
    cyc();
    a_in_val[0] = 1'b0;
    cyc(3);

    // Fill lane 0 with 1..4, hold 5 while full, then drain.
    a_out_rdy[0] = 1'b0;
    for (int v = 1; v <= 4; v++) begin
      a_in_val[0] = 1'b1; a_in_msg[0] = 32'(v);
      cyc();
    end
    a_in_msg[0] = 32'h5;
    cyc(3);
    a_out_rdy[0] = 1'b1;
    cyc(2);
    a_in_val[0] = 1'b0;
    cyc(6);

    // Half-full lane 1 streaming 100 incrementing values.
    a_out_rdy[1] = 1'b0;
    for (int v = 0; v < 2; v++) begin
      a_in_val[1] = 1'b1; a_in_msg[1] = seq; seq++;
      cyc();
    end
    a_out_rdy[1] = 1'b1;
    for (int v = 0; v < 100; v++) begin
      a_in_msg[1] = seq; seq++;
      cyc();
    end
    a_in_val[1] = 1'b0;
    cyc(4);

    // Depth-1 lane with continuous val/rdy: one message every two cycles.
    b_in_val[0] = 1'b1; b_out_rdy[0] = 1'b1;
    for (int v = 0; v < 20; v++) begin
      b_in_msg[0] = seq; seq++;
      cyc();
    end
    idle_all(1'b1);
    cyc(4);

    // Lane independence with lane 2 permanently backpressured.
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < NA; i++) begin
        a_in_val[i]  = 1'($urandom);
        a_out_rdy[i] = (i == 2) ? 1'b0 : 1'($urandom);
        a_in_msg[i]  = $urandom;
      end
      rand_b();
      cyc();
    end

    // Reset mid-operation: 3 messages queued in lanes 0 and 1, pulse with in_val high.
    idle_all(1'b1);
    cyc(8);
    idle_all(1'b0);
    for (int v = 0; v < 3; v++) begin
      a_in_val[0] = 1'b1; a_in_msg[0] = seq; seq++;
      a_in_val[1] = 1'b1; a_in_msg[1] = seq; seq++;
      cyc();
    end
    reset = 1'b1;
    a_in_msg[0] = 32'hBAD0; a_in_msg[1] = 32'hBAD1;
    cyc();
    reset = 1'b0;
    idle_all(1'b1);
    cyc(3);

    // Random traffic on everything with occasional reset.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NA; i++) begin
        a_in_val[i]  = 1'($urandom);
        a_out_rdy[i] = ($urandom_range(0, 3) != 0);
        a_in_msg[i]  = $urandom;
      end
      rand_b();
      reset = ($urandom_range(0, 99) == 0);
      cyc();
    end
    reset = 1'b0;
    idle_all(1'b1);
    cyc(8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pass_through_queue_array.md
# pass_through_queue_array

Parametrised successor to the plain port-array pass-through. It carries `nports` independent lanes of `nbits`-wide messages, and each lane is buffered by its own `nentries`-deep FIFO with a val/rdy handshake on both sides. It sits between producer and consumer port arrays wherever lanes need decoupling and backpressure rather than a wire connection. Lanes share only the clock and reset.

## Interface

Parameters:
- `nports`, default 2: number of independent lanes; must be ≥ 1.
- `nbits`, default 32: message width in bits; must be ≥ 1.
- `nentries`, default 2: FIFO depth per lane; must be ≥ 1 and need not be a power of two.
- Derived `cbits` = $clog2(nentries+1): width of the occupancy count.

Ports (all port arrays are unpacked, indexed `[nports]`):
- `clk`  input  1  single clock; all state updates on its rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `in_val`  input  1 ×nports  producer asserts that `in_msg[i]` is valid.
- `in_rdy`  output  1 ×nports  lane i can accept a message this cycle.
- `in_msg`  input  nbits ×nports  enqueue data.
- `out_val`  output  1 ×nports  `out_msg[i]` holds valid head-of-queue data.
- `out_rdy`  input  1 ×nports  consumer accepts the head of lane i.
- `out_msg`  output  nbits ×nports  head-of-queue data.
- `count`  output  cbits ×nports  current occupancy of lane i.

## Operation

Each lane i has:
- a storage array of `nentries` × `nbits`;
- head and tail pointers, each of width max(1, $clog2(nentries));
- an occupancy counter `count[i]`.

Handshake and flag rules:
- Enqueue fires when `in_val[i] && in_rdy[i]`. Data is written at the tail and the tail advances.
- Dequeue fires when `out_val[i] && out_rdy[i]`. The head advances.
- Pointers wrap from `nentries-1` to 0. Wrap is an explicit compare, not modulo 2^n, so non-power-of-two depths work.
- `in_rdy[i] = !reset && (count[i] < nentries)`. It depends only on state and must not depend combinationally on `out_rdy[i]`, so there is no pipe behaviour: a full lane refuses enqueue even when a dequeue happens in the same cycle.
- `out_val[i] = !reset && (count[i] != 0)`.
- `out_msg[i]` = storage[head]. Its value is undefined when `out_val[i]=0`, and the bench must not check it then.
- No bypass: a message enqueued into an empty lane appears at the output the next cycle.

Count update per cycle:
- +1 on enqueue only.
- −1 on dequeue only.
- Unchanged on both or neither.
- Count never exceeds `nentries` and never underflows. These are assertion conditions.

Other rules:
- Ordering is strict FIFO per lane. There is no ordering relation between lanes.
- Handshake events on one lane never affect another lane.
- A held message is stable: while `out_val[i]=1` and `out_rdy[i]=0`, `out_msg[i]` does not change, including across enqueues into the same lane.

## Timing

- Reset: while `reset`=1, `in_rdy` and `out_val` are 0 on all lanes and no handshake fires.
- At the first rising edge with `reset`=1, every lane sets count=0, head=0 and tail=0.
- After reset deasserts, the first cycle shows `in_rdy`=1, `out_val`=0 and `count`=0 on all lanes.
- Storage contents are not reset.
- Reset asserted mid-operation discards all queued messages in every lane at that edge. Messages presented during reset cycles are dropped.
- Latency: 1 cycle minimum from enqueue to `out_val`. Equivalently, an enqueue at edge k is visible after edge k.
- Throughput: 1 message/cycle/lane whenever the lane is neither empty nor full. With `nentries=1`, sustained throughput is 1 message every 2 cycles, because full blocks enqueue.
- Full lane with `out_rdy`=1: the dequeue fires, and `in_rdy` rises in the following cycle.
- Empty lane with `in_val`=1: the enqueue fires, and the dequeue becomes possible the next cycle.
- All outputs are registered or are functions of registered state only. There is no combinational path from any input to any output.

## Test plan

- **Single message:** reset, then `in_val[0]=1` with `in_msg[0]=0xDEADBEEF` for 1 cycle and `out_rdy[0]=1`. Required: `out_val[0]=1` with `0xDEADBEEF` exactly 1 cycle later; `count[0]` goes 0→1→0; lane 1 stays `out_val`=0.
- **Fill and drain:** `nentries=4`, `out_rdy=0`, enqueue 0x1..0x5 back-to-back. Required: `in_rdy` drops after the 4th message and the 5th is held; `count`=4. Then set `out_rdy=1`. Required: outputs 0x1, 0x2, 0x3, 0x4 in order, then 0x5 after it is accepted.
- **Simultaneous enqueue/dequeue:** half-full lane with continuous `in_val`/`out_rdy` streaming 100 incrementing values. Required: 1 message/cycle, `count` constant, in-order output, pointers wrapping several times.
- **Full-lane stall:** `nentries=1` with continuous `in_val`/`out_rdy`. Required: `in_rdy` alternates 1,0,1,0 and one message is accepted every 2 cycles; with `out_rdy` held 1 while full, no enqueue fires in the same cycle as the dequeue.
- **Lane independence:** `nports=4`, random val/rdy per lane, with lane 2 permanently backpressured. Required: lanes 0, 1 and 3 deliver their own streams in order; lane 2 holds `count=nentries` and a stable `out_msg`.
- **Reset mid-operation:** 3 messages queued in lanes 0 and 1, then `reset` pulsed for 1 cycle with `in_val`=1. Required: all `count`=0, `out_val`=0 and `in_rdy`=1 after the pulse, and no message accepted during the pulse.
